// File: rtl/axi_snoop_stream_arbiter_if.sv
// Bundle between the snoop submodules, the stream arbiter and the AXI4-Stream sink.
// master = arbiter side, slave = submodules plus downstream sink.
interface axi_snoop_stream_arbiter_if #(
  parameter int NUM_SRC    = 5,
  parameter int DATA_WIDTH = 128,
  parameter int SRC_IDX_W  = 3
);
  logic [NUM_SRC-1:0]            src_ready;
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_in_progress;
  logic [NUM_SRC-1:0]            src_last;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [DATA_WIDTH-1:0]         M_AXIS_tdata;
  logic                          M_AXIS_tvalid;
  logic                          M_AXIS_tlast;
  logic [SRC_IDX_W-1:0]          M_AXIS_tuser;
  logic                          M_AXIS_tready;

  modport master (
    output src_ready, M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tuser,
    input  src_valid, src_in_progress, src_last, src_data, M_AXIS_tready
  );

  modport slave (
    input  src_ready, M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tuser,
    output src_valid, src_in_progress, src_last, src_data, M_AXIS_tready
  );
endinterface

// File: rtl/axi_snoop_stream_arbiter.sv
// Grants one snoop submodule at a time (round-robin offer, burst lock until last)
// and queues captured beats in a 2-entry FIFO feeding one AXI4-Stream master.
module axi_snoop_stream_arbiter #(
  parameter int NUM_SRC    = 5,
  parameter int DATA_WIDTH = 128,
  parameter int SRC_IDX_W  = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  axi_snoop_stream_arbiter_if.master      bus,
  output logic                            proto_err
);
  typedef enum logic {IDLE, LOCKED} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [SRC_IDX_W-1:0]  src;
  } beat_t;

  state_e               state_q;
  logic [SRC_IDX_W-1:0] ptr_q, grant_q, sel;
  logic                 proto_err_q;
  logic [1:0]           cnt_q, cnt_d;
  logic                 wr_q, rd_q;
  beat_t                mem_q [2];

  logic                 space, push, pop, push_last;
  logic [DATA_WIDTH-1:0] push_data;
  logic [NUM_SRC-1:0]   ready;

  function automatic logic [SRC_IDX_W-1:0] inc(input logic [SRC_IDX_W-1:0] x);
    return (x == SRC_IDX_W'(NUM_SRC-1)) ? '0 : x + 1'b1;
  endfunction

  assign sel   = (state_q == LOCKED) ? grant_q : ptr_q;
  assign space = (cnt_q != 2'd2);

  // Ready is gated by reset directly so nothing is offered while reset is held.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_rdy
    assign ready[g] = !reset && space && (sel == SRC_IDX_W'(g));
  end

  assign bus.src_ready = ready;
  assign push      = |(bus.src_valid & ready);
  assign push_last = bus.src_last[sel];
  assign push_data = bus.src_data[sel*DATA_WIDTH +: DATA_WIDTH];
  assign pop       = (cnt_q != 2'd0) && bus.M_AXIS_tready;
  assign cnt_d     = cnt_q + 2'(push) - 2'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push && !push_last) begin
            state_q <= LOCKED;
            grant_q <= ptr_q;
          end else begin
            ptr_q <= inc(ptr_q);
          end
        end
        LOCKED: begin
          if (push && push_last) begin
            state_q <= IDLE;
            ptr_q   <= inc(grant_q);
          end else if (!push && space && !bus.src_in_progress[grant_q]
                       && !bus.src_valid[grant_q]) begin
            // Burst abandoned without last: flag it and release the lock.
            proto_err_q <= 1'b1;
            state_q     <= IDLE;
            ptr_q       <= inc(grant_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_q <= ~wr_q;
      if (pop)  rd_q <= ~rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= '{data: push_data, last: push_last, src: sel};
  end

  assign bus.M_AXIS_tvalid = (cnt_q != 2'd0);
  assign bus.M_AXIS_tdata  = mem_q[rd_q].data;
  assign bus.M_AXIS_tlast  = mem_q[rd_q].last;
  assign bus.M_AXIS_tuser  = mem_q[rd_q].src;
  assign proto_err         = proto_err_q;
endmodule

// File: tb/tb_axi_snoop_stream_arbiter.sv
// Directed bench for axi_snoop_stream_arbiter: hand-computed grants, ordering and errors.
module tb_axi_snoop_stream_arbiter;
  localparam int NS = 5;
  localparam int DW = 128;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic reset;
  logic proto_err;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [IW-1:0] u;
  } beat_t;
  beat_t mon_q[$];

  axi_snoop_stream_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW), .SRC_IDX_W(IW)) bus ();

  axi_snoop_stream_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .SRC_IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && bus.M_AXIS_tvalid && bus.M_AXIS_tready)
      mon_q.push_back('{bus.M_AXIS_tdata, bus.M_AXIS_tlast, bus.M_AXIS_tuser});

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_src();
    bus.src_valid = '0; bus.src_last = '0; bus.src_in_progress = '0; bus.src_data = '0;
  endtask

  task automatic set_beat(input int i, input logic [DW-1:0] d, input logic last);
    bus.src_valid[i] = 1'b1;
    bus.src_last[i]  = last;
    bus.src_data[i*DW +: DW] = d;
  endtask

  task automatic wait_ready(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2*NS && !ok; c++) begin
      if (bus.src_ready[i]) ok = 1'b1;
      else step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clear_src(); bus.M_AXIS_tready = 1'b0;
    step(); step();
    checks++; if (bus.src_ready !== '0) begin failures++; $display("FAIL rst_ready: got %b want 00000", bus.src_ready); end
    checks++; if (bus.M_AXIS_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b want 0", bus.M_AXIS_tvalid); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rst_perr: got %b want 0", proto_err); end
    reset = 1'b0; #1;
    checks++; if (bus.src_ready !== 5'b00001) begin failures++; $display("FAIL rst_ptr0: got %b want 00001", bus.src_ready); end
    step();
    checks++; if (bus.src_ready !== 5'b00010) begin failures++; $display("FAIL rst_rotate: got %b want 00010", bus.src_ready); end
  endtask

  task automatic test_single_b();
    bit ok;
    mon_q.delete(); bus.M_AXIS_tready = 1'b1;
    wait_ready(2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_wait: src2 never offered"); end
    set_beat(2, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, 1'b1);
    step(); clear_src();
    checks++; if (bus.M_AXIS_tvalid !== 1'b1 || bus.M_AXIS_tuser !== 3'd2 || bus.M_AXIS_tlast !== 1'b1)
      begin failures++; $display("FAIL single_head: got v=%b u=%0d l=%b want v=1 u=2 l=1", bus.M_AXIS_tvalid, bus.M_AXIS_tuser, bus.M_AXIS_tlast); end
    checks++; if (bus.M_AXIS_tdata !== 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978)
      begin failures++; $display("FAIL single_data: got %h", bus.M_AXIS_tdata); end
    checks++; if (bus.src_ready !== 5'b01000) begin failures++; $display("FAIL single_ptr: got %b want 01000", bus.src_ready); end
    step();
    checks++; if (bus.M_AXIS_tvalid !== 1'b0) begin failures++; $display("FAIL single_pop: got %b want 0", bus.M_AXIS_tvalid); end
  endtask

  task automatic test_burst();
    bit ok;
    int b;
    logic [5:0] vld;
    vld = 6'b110011; b = 0;
    mon_q.delete(); bus.M_AXIS_tready = 1'b1;
    wait_ready(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_wait: src1 never offered"); end
    bus.src_in_progress[1] = 1'b1; bus.src_in_progress[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.src_ready !== 5'b00010) begin failures++; $display("FAIL burst_ready[%0d]: got %b want 00010", k, bus.src_ready); end
      if (vld[5-k]) begin set_beat(1, DW'(32'hB0 + b), b == 3); b++; end
      else bus.src_valid[1] = 1'b0;
      step();
    end
    bus.src_valid[1] = 1'b0; bus.src_last[1] = 1'b0; bus.src_in_progress[1] = 1'b0;
    wait_ready(3, ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_src3_wait: src3 never offered"); end
    set_beat(3, DW'(32'hC3), 1'b1);
    step(); clear_src(); step(); step();
    checks++; if (mon_q.size() != 5) begin failures++; $display("FAIL burst_count: got %0d want 5", mon_q.size()); end
    else begin
      for (int j = 0; j < 4; j++) begin
        checks++; if (mon_q[j].u !== 3'd1 || mon_q[j].d !== DW'(32'hB0 + j) || mon_q[j].l !== (j == 3))
          begin failures++; $display("FAIL burst_beat[%0d]: got u=%0d d=%0h l=%b", j, mon_q[j].u, mon_q[j].d, mon_q[j].l); end
      end
      checks++; if (mon_q[4].u !== 3'd3 || mon_q[4].d !== DW'(32'hC3))
        begin failures++; $display("FAIL burst_src3: got u=%0d d=%0h want u=3 d=c3", mon_q[4].u, mon_q[4].d); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int sent;
    sent = 0;
    mon_q.delete(); bus.M_AXIS_tready = 1'b0;
    wait_ready(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_wait: src0 never offered"); end
    bus.src_in_progress[0] = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.M_AXIS_tready = (cyc >= 5);
      if (cyc >= 2 && cyc <= 4) begin
        checks++; if (bus.src_ready !== '0 || bus.M_AXIS_tvalid !== 1'b1)
          begin failures++; $display("FAIL bp_full[%0d]: got rdy=%b v=%b want 00000 1", cyc, bus.src_ready, bus.M_AXIS_tvalid); end
      end
      if (bus.src_ready[0] && sent < 4) begin set_beat(0, DW'(32'hD0 + sent), sent == 3); sent++; end
      else bus.src_valid[0] = 1'b0;
      step();
    end
    clear_src();
    checks++; if (sent != 4 || mon_q.size() != 4)
      begin failures++; $display("FAIL bp_count: got sent=%0d out=%0d want 4 4", sent, mon_q.size()); end
    else begin
      for (int j = 0; j < 4; j++) begin
        checks++; if (mon_q[j].u !== 3'd0 || mon_q[j].d !== DW'(32'hD0 + j) || mon_q[j].l !== (j == 3))
          begin failures++; $display("FAIL bp_beat[%0d]: got u=%0d d=%0h l=%b", j, mon_q[j].u, mon_q[j].d, mon_q[j].l); end
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_src;
    logic [NS-1:0] exp_rdy;
    mon_q.delete(); bus.M_AXIS_tready = 1'b1; exp_src = 0;
    wait_ready(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_wait: src0 never offered"); end
    bus.src_last = '1;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = NS'(1) << exp_src;
      checks++; if (bus.src_ready !== exp_rdy) begin failures++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.src_ready, exp_rdy); end
      if (k > 0) begin
        checks++; if (bus.M_AXIS_tvalid !== 1'b1) begin failures++; $display("FAIL rr_tput[%0d]: got tvalid=%b want 1", k, bus.M_AXIS_tvalid); end
      end
      for (int i = 0; i < NS; i++) bus.src_data[i*DW +: DW] = DW'(16*k + i);
      bus.src_valid = bus.src_ready;
      step();
      exp_src = (exp_src + 1) % NS;
    end
    clear_src(); step(); step();
    checks++; if (mon_q.size() != 6) begin failures++; $display("FAIL rr_count: got %0d want 6", mon_q.size()); end
    else begin
      for (int j = 0; j < 6; j++) begin
        checks++; if (mon_q[j].u !== IW'(j % NS) || mon_q[j].d !== DW'(16*j + j % NS) || mon_q[j].l !== 1'b1)
          begin failures++; $display("FAIL rr_beat[%0d]: got u=%0d d=%0h l=%b", j, mon_q[j].u, mon_q[j].d, mon_q[j].l); end
      end
    end
  endtask

  task automatic test_proto_err();
    bit ok;
    mon_q.delete(); bus.M_AXIS_tready = 1'b1;
    wait_ready(4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL perr_wait: src4 never offered"); end
    bus.src_in_progress[4] = 1'b1;
    set_beat(4, DW'(32'hF4), 1'b0);
    step();
    bus.src_valid[4] = 1'b0; bus.src_in_progress[4] = 1'b0;
    checks++; if (bus.src_ready !== 5'b10000 || proto_err !== 1'b0)
      begin failures++; $display("FAIL perr_locked: got rdy=%b err=%b want 10000 0", bus.src_ready, proto_err); end
    step();
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL perr_set: got %b want 1", proto_err); end
    checks++; if (bus.src_ready !== 5'b00001) begin failures++; $display("FAIL perr_ptr0: got %b want 00001", bus.src_ready); end
    set_beat(0, DW'(32'hA0), 1'b1);
    step(); clear_src();
    checks++; if (bus.M_AXIS_tvalid !== 1'b1 || bus.M_AXIS_tuser !== 3'd0 || bus.M_AXIS_tdata !== DW'(32'hA0) || bus.M_AXIS_tlast !== 1'b1)
      begin failures++; $display("FAIL perr_next: got v=%b u=%0d d=%0h l=%b", bus.M_AXIS_tvalid, bus.M_AXIS_tuser, bus.M_AXIS_tdata, bus.M_AXIS_tlast); end
    step(); step();
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL perr_sticky: got %b want 1", proto_err); end
    checks++; if (mon_q.size() != 2 || mon_q[0].l !== 1'b0 || mon_q[0].u !== 3'd4)
      begin failures++; $display("FAIL perr_stream: got n=%0d first_l=%b first_u=%0d want 2 0 4", mon_q.size(), mon_q[0].l, mon_q[0].u); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    mon_q.delete(); bus.M_AXIS_tready = 1'b0;
    wait_ready(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rm_wait: src1 never offered"); end
    bus.src_in_progress[1] = 1'b1;
    set_beat(1, DW'(32'h11), 1'b0); step();
    set_beat(1, DW'(32'h12), 1'b0); step();
    bus.src_valid = '0;
    checks++; if (bus.M_AXIS_tvalid !== 1'b1 || bus.src_ready !== '0)
      begin failures++; $display("FAIL rm_full: got v=%b rdy=%b want 1 00000", bus.M_AXIS_tvalid, bus.src_ready); end
    reset = 1'b1; #1;
    checks++; if (bus.src_ready !== '0) begin failures++; $display("FAIL rm_rst_ready: got %b want 00000", bus.src_ready); end
    step(); clear_src();
    checks++; if (bus.src_ready !== '0) begin failures++; $display("FAIL rm_rst_gate: got %b want 00000", bus.src_ready); end
    checks++; if (bus.M_AXIS_tvalid !== 1'b0) begin failures++; $display("FAIL rm_flush: got %b want 0", bus.M_AXIS_tvalid); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rm_perr_clr: got %b want 0", proto_err); end
    reset = 1'b0; #1;
    checks++; if (bus.src_ready !== 5'b00001) begin failures++; $display("FAIL rm_ptr0: got %b want 00001", bus.src_ready); end
    bus.M_AXIS_tready = 1'b1;
    set_beat(0, DW'(32'h77), 1'b1);
    step(); clear_src();
    checks++; if (bus.M_AXIS_tvalid !== 1'b1 || bus.M_AXIS_tuser !== 3'd0 || bus.M_AXIS_tdata !== DW'(32'h77) || bus.M_AXIS_tlast !== 1'b1)
      begin failures++; $display("FAIL rm_fresh: got v=%b u=%0d d=%0h l=%b", bus.M_AXIS_tvalid, bus.M_AXIS_tuser, bus.M_AXIS_tdata, bus.M_AXIS_tlast); end
    step();
    checks++; if (bus.M_AXIS_tvalid !== 1'b0) begin failures++; $display("FAIL rm_drain: got %b want 0", bus.M_AXIS_tvalid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_b();
    test_burst();
    test_backpressure();
    test_round_robin();
    test_proto_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
